// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 keypad, debounces whole scans and emits one key code per press.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_strobe
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SCANS);
  localparam logic [3:0] NO_KEY = 4'd13;
  localparam logic [47:0] KEY_MAP = {4'd10, 4'd0, 4'd11, 4'd9, 4'd8, 4'd7,
                                     4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  typedef enum logic {IDLE, HELD} state_t;
  state_t state_q, state_d;
  logic [2:0] c1_q, c2_q;
  logic [1:0] row_q, row_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [8:0] acc_q, acc_d;
  logic [DW-1:0] press_q, press_d, rel_q, rel_d;
  logic [3:0] cand_q, cand_d, code_q, code_d;
  logic strobe_q, strobe_d;
  logic sample, scan_done;
  logic [11:0] keys;
  logic [3:0] n_keys, hit_code;
  assign row_n = ~(4'b0001 << row_q);
  assign key_code = code_q;
  assign key_strobe = strobe_q;
  always_comb begin
    sample = settle_q == SW'(SETTLE_CYCLES - 1);
    scan_done = sample && row_q == 2'd3;
    settle_d = sample ? '0 : settle_q + 1'b1;
    row_d = sample ? row_q + 2'd1 : row_q;
    acc_d = acc_q;
    if (sample && row_q != 2'd3) acc_d[row_q*3 +: 3] = ~c2_q;
    // The row 3 columns are classified straight from the synchroniser, so the scan resolves on its last sample edge
    keys = {~c2_q, acc_q};
    n_keys = 4'd0;
    hit_code = NO_KEY;
    for (int i = 0; i < 12; i++) begin
      n_keys = keys[i] ? n_keys + 4'd1 : n_keys;
      hit_code = keys[i] ? KEY_MAP[i*4 +: 4] : hit_code;
    end
    state_d = state_q;
    press_d = press_q;
    rel_d = rel_q;
    cand_d = cand_q;
    code_d = NO_KEY;
    strobe_d = 1'b0;
    if (scan_done && state_q == IDLE) begin
      if (n_keys == 4'd1) begin
        press_d = hit_code != cand_q ? DW'(1) : press_q == DMAX ? press_q : press_q + 1'b1;
        cand_d = hit_code;
        if (press_d == DMAX) begin
          code_d = hit_code;
          strobe_d = 1'b1;
          state_d = HELD;
        end
      end else begin
        press_d = '0;
        cand_d = NO_KEY;
      end
    end else if (scan_done) begin
      rel_d = n_keys != 4'd0 ? '0 : rel_q == DMAX ? rel_q : rel_q + 1'b1;
      if (rel_d == DMAX) begin
        state_d = IDLE;
        press_d = '0;
        rel_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c1_q <= 3'b111;
      c2_q <= 3'b111;
      row_q <= '0;
      settle_q <= '0;
      acc_q <= '0;
      press_q <= '0;
      rel_q <= '0;
      cand_q <= NO_KEY;
      code_q <= NO_KEY;
      strobe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q <= col_n;
      c2_q <= c1_q;
      row_q <= row_d;
      settle_q <= settle_d;
      acc_q <= acc_d;
      press_q <= press_d;
      rel_q <= rel_d;
      cand_q <= cand_d;
      code_q <= code_d;
      strobe_q <= strobe_d;
    end
  end
endmodule
